// File: rtl/imm_extender_pipe_if.sv
// Valid/ready stream bundle for the pipelined immediate extender.
// Master is the producer/consumer side; slave is the extender itself.
interface imm_extender_pipe_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;

   modport master (
      output in_valid, in_imm, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_imm, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/imm_extender_pipe.sv
// Pipelined immediate extender: zero/sign/upper/shifted-sign modes behind an output register plus skid entry.
// Optional macro IMM_EXT_COUNT_EN adds a 16-bit wrapping count of output transfers (beat_count).
module imm_extender_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2
) (
   input logic clk,
   input logic rst,
   imm_extender_pipe_if.slave bus
`ifdef IMM_EXT_COUNT_EN
   ,
   output logic [15:0] beat_count
`endif
);

   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] upper;
   logic [OUT_W-1:0] ext;

   logic             out_valid_reg;
   logic [OUT_W-1:0] out_data_reg;
   logic             skid_valid_reg;
   logic [OUT_W-1:0] skid_data_reg;

   logic in_fire;
   logic out_free;

   // Bitwise build of the candidate extensions; every index is resolved at elaboration.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_W; gi++) begin : g_bits
         if (gi < IN_W) begin : g_low
            assign zext[gi] = bus.in_imm[gi];
            assign sext[gi] = bus.in_imm[gi];
         end else begin : g_high
            assign zext[gi] = 1'b0;
            assign sext[gi] = bus.in_imm[IN_W-1];
         end
         if (gi >= OUT_W - IN_W) begin : g_up
            assign upper[gi] = bus.in_imm[gi-(OUT_W-IN_W)];
         end else begin : g_up0
            assign upper[gi] = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      ext = zext;
      unique case (bus.in_mode)
         2'b00:   ext = zext;
         2'b01:   ext = sext;
         2'b10:   ext = upper;
         default: ext = sext << SHIFT;
      endcase
   end

   // in_ready depends only on registered state, never on out_ready.
   assign bus.in_ready  = ~skid_valid_reg;
   assign in_fire       = bus.in_valid & ~skid_valid_reg;
   assign out_free      = ~out_valid_reg | bus.out_ready;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
      end else if (out_free) begin
         if (skid_valid_reg) begin
            out_data_reg   <= skid_data_reg;
            out_valid_reg  <= 1'b1;
            skid_valid_reg <= 1'b0;
         end else if (in_fire) begin
            out_data_reg  <= ext;
            out_valid_reg <= 1'b1;
         end else begin
            out_valid_reg <= 1'b0;
         end
      end else if (in_fire) begin
         skid_data_reg  <= ext;
         skid_valid_reg <= 1'b1;
      end
   end

`ifdef IMM_EXT_COUNT_EN
   logic [15:0] beat_count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_count_reg <= '0;
      end else if (out_valid_reg && bus.out_ready) begin
         beat_count_reg <= beat_count_reg + 16'd1;
      end
   end

   assign beat_count = beat_count_reg;
`endif

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Directed self-checking bench for imm_extender_pipe (defaults IN_W=16, OUT_W=32, SHIFT=2).
// Covers all four modes, backpressure through the skid entry, streaming, async reset, optional counter.
module tb_imm_extender_pipe;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   imm_extender_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

`ifdef IMM_EXT_COUNT_EN
   logic [15:0] beat_count;
`endif

   imm_extender_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef IMM_EXT_COUNT_EN
      ,
      .beat_count (beat_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp);
      bus.in_valid = 1'b1;
      bus.in_imm   = imm;
      bus.in_mode  = mode;
      check("send_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.in_valid = 1'b0;
      check("mode_valid", {31'd0, bus.out_valid}, 32'd1);
      check("mode_data", bus.out_data, exp);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      bus.in_valid  = 1'b0;
      bus.in_imm    = '0;
      bus.in_mode   = 2'b00;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      #2;
      check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_data", bus.out_data, 32'd0);
      step();
      step();
      rst = 1'b0;
      step();
      check("ready_after", {31'd0, bus.in_ready}, 32'd1);

      // Extension modes with a free consumer
      bus.out_ready = 1'b1;
      send(16'h8001, 2'b00, 32'h0000_8001);
      send(16'h8001, 2'b01, 32'hFFFF_8001);
      send(16'h7FFF, 2'b01, 32'h0000_7FFF);
      send(16'h1234, 2'b10, 32'h1234_0000);
      send(16'hFFFF, 2'b11, 32'hFFFF_FFFC);
      send(16'h4000, 2'b11, 32'h0001_0000);
      send(16'h8000, 2'b11, 32'hFFFE_0000);
      send(16'hABCD, 2'b00, 32'h0000_ABCD);
      step();
      check("idle_valid", {31'd0, bus.out_valid}, 32'd0);

      // Backpressure: A into output, B into skid, C held off
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_mode   = 2'b00;
      bus.in_imm    = 16'h0001;
      step();
      check("bp_a_data", bus.out_data, 32'h0000_0001);
      check("bp_a_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.in_imm = 16'h0002;
      step();
      check("bp_b_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_hold", bus.out_data, 32'h0000_0001);
      bus.in_imm = 16'h0003;
      step();
      check("bp_c_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_hold2", bus.out_data, 32'h0000_0001);
      check("bp_hold_v", {31'd0, bus.out_valid}, 32'd1);
      bus.out_ready = 1'b1;
      step();
      check("bp_out_b", bus.out_data, 32'h0000_0002);
      check("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
      step();
      check("bp_out_c", bus.out_data, 32'h0000_0003);
      check("bp_out_c_v", {31'd0, bus.out_valid}, 32'd1);
      bus.in_valid = 1'b0;
      step();
      check("bp_drain", {31'd0, bus.out_valid}, 32'd0);

      // Streaming: one result per cycle, no bubbles
      bus.in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_imm = 16'h0010 + 16'(i);
         step();
         check("strm_valid", {31'd0, bus.out_valid}, 32'd1);
         check("strm_data", bus.out_data, 32'h0000_0010 + 32'(i));
         check("strm_ready", {31'd0, bus.in_ready}, 32'd1);
      end
      bus.in_valid = 1'b0;
      step();
      check("strm_end", {31'd0, bus.out_valid}, 32'd0);

      // Reset with skid full, asserted between edges
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_imm    = 16'h0055;
      step();
      bus.in_imm = 16'h0066;
      step();
      bus.in_valid = 1'b0;
      check("skid_full", {31'd0, bus.in_ready}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("arst_data", bus.out_data, 32'd0);
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step();
      check("rel_ready", {31'd0, bus.in_ready}, 32'd1);
      check("no_old1", {31'd0, bus.out_valid}, 32'd0);
      step();
      check("no_old2", {31'd0, bus.out_valid}, 32'd0);

`ifdef IMM_EXT_COUNT_EN
      check("cnt_rst", {16'd0, beat_count}, 32'd0);
      bus.in_valid = 1'b1;
      bus.in_mode  = 2'b00;
      for (int i = 0; i < 5; i++) begin
         bus.in_imm = 16'(i);
         step();
      end
      bus.in_valid = 1'b0;
      step();
      check("cnt_5", {16'd0, beat_count}, 32'd5);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 65530; i++) step();
      bus.in_valid = 1'b0;
      step();
      check("cnt_ffff", {16'd0, beat_count}, 32'h0000_FFFF);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      check("cnt_wrap", {16'd0, beat_count}, 32'd0);
`endif

      send(16'h0077, 2'b00, 32'h0000_0077);
      step();
      check("final_idle", {31'd0, bus.out_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
